password_entry: RTL and testbench
=================================

Name: password_entry

Overview:
- Upstream feeder for the access-control stage.
- Collects NUM_DIGITS keypad/switch digits, one per button press, and assembles them into one password word.
- Presents the word with a single-cycle load strobe, wired directly to the access-control data input and data-load pins.
- Also provides entry progress and clear handling for the status/display logic.

Parameters:
- DIGIT_W, 4: bits per digit.
- NUM_DIGITS, 4: digits per password; word width is DIGIT_W*NUM_DIGITS (16).
- TIMEOUT_CYCLES, 50000000: idle cycles before a partial entry is discarded. Used only with PASSWORD_ENTRY_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- digit_in  in  DIGIT_W  digit value on switches, sampled on a digit_btn rising edge
- digit_btn  in  1  digit-enter button, level, already synchronized/debounced, active-high
- clear_btn  in  1  clear button, level, already synchronized/debounced, active-high
- data_out  out  DIGIT_W*NUM_DIGITS  last completed password word
- data_load  out  1  one-cycle strobe; data_out is valid in that cycle
- digit_count  out  3  digits accepted in the current entry, 0..NUM_DIGITS-1
- entry_active  out  1  high while a partial entry is held (state COLLECT)
- entry_timeout  out  1  one-cycle strobe on timeout discard; constant 0 without the macro

Behaviour:
- Reset (synchronous, active-high):
  - data_out=0, data_load=0, digit_count=0, entry_active=0, entry_timeout=0.
  - Internal shift register cleared; state=IDLE.
  - Button history registers reset to 1, so a button held through reset produces no edge after release.
  - Reset during an entry discards the entry, with no load.
- Edge detection:
  - Event = btn & ~btn_q, where btn_q is btn registered once.
  - Holding a button yields exactly one event.
- State machine (IDLE, COLLECT, EMIT):
  - IDLE: a digit event shifts digit_in into the LSBs (shift left by DIGIT_W) and sets count=1. Next state is COLLECT, or EMIT directly if NUM_DIGITS==1.
  - COLLECT, digit event with count<NUM_DIGITS-1: shift in, count++.
  - COLLECT, digit event with count==NUM_DIGITS-1 (final digit): at that clock edge, data_out takes the shifted word and data_load goes 1. Next state is EMIT; count returns to 0.
  - EMIT: lasts exactly one cycle with data_load=1, then returns to IDLE. Digit and clear events during EMIT are ignored.
- Word ordering: the first digit entered occupies data_out[15:12]; the last occupies [3:0].
- Latency: final digit_btn rising edge sampled at clock edge k → data_load high from edge k to edge k+1.
- data_out is stable between loads. It is not updated during a partial entry.
- Clear event in IDLE or COLLECT: discards the shift register, count=0, state=IDLE, no data_load.
- Simultaneous clear and digit events in the same cycle: clear wins and the digit is dropped.
- entry_active = (state==COLLECT).

Optional Feature:
- Macro: PASSWORD_ENTRY_TIMEOUT_EN.
- Defined:
  - An idle counter runs only in COLLECT and resets to 0 on every accepted digit and on entry to COLLECT.
  - When the counter reaches TIMEOUT_CYCLES-1, the entry is discarded exactly as a clear, and entry_timeout pulses for one cycle.
  - A digit event in the same cycle as expiry is accepted, and the counter resets.
- Not defined: no counter logic; entry_timeout tied to 0; partial entries persist indefinitely.

Decomposition:
- Shared package: DIGIT_W and NUM_DIGITS defaults, derived PW_W = DIGIT_W*NUM_DIGITS, and the state encoding (IDLE=2'd0, COLLECT=2'd1, EMIT=2'd2).
- One sub-module: rise_edge_detect (1-bit registered rising-edge one-shot, reset value 1), instantiated for digit_btn and clear_btn.

Test Plan:
- Enter digits 1,2,3,4 (one press each, 3-cycle holds) → a single data_load pulse one cycle wide, data_out=16'h1234, digit_count back to 0, entry_active 0 after EMIT.
- Enter 5,6 then clear, then enter A,B,C,D → no load after 5,6; one load with data_out=16'hABCD; previous data_out retained until then.
- Hold digit_btn for 20 cycles with digit_in=7 → exactly one digit accepted, digit_count=1. Clear and digit events in the same cycle → count=0, no shift.
- Assert rst for 1 cycle after 3 digits while digit_btn is held high → all outputs 0; after release with the button still held, no digit accepted until it is released and pressed again.
- Press a digit during the EMIT cycle (4th press followed 1 cycle later by another edge) → second press ignored, digit_count stays 0, data_out unchanged.
- With PASSWORD_ENTRY_TIMEOUT_EN and TIMEOUT_CYCLES=10, enter 2 digits and idle → entry_timeout pulses 10 cycles after the last accepted digit, count=0, no load. Without the macro, the entry is retained after 1000 idle cycles.

Source files
------------

// File: rtl/password_entry_pkg.sv
// Shared constants for the password entry block.
// Default digit geometry and the FSM state encoding.
package password_entry_pkg;

  localparam int DEF_DIGIT_W    = 4;
  localparam int DEF_NUM_DIGITS = 4;
  localparam int DEF_PW_W       = DEF_DIGIT_W * DEF_NUM_DIGITS;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] EMIT    = 2'd2;

endpackage

// File: rtl/password_entry_if.sv
// Keypad-side inputs and access-control-side outputs of password_entry.
// slave: the entry block; master: keypad driver / downstream consumer.
interface password_entry_if
  import password_entry_pkg::*;
#(
  parameter int DIGIT_W    = DEF_DIGIT_W,
  parameter int NUM_DIGITS = DEF_NUM_DIGITS
) ();

  logic [DIGIT_W-1:0]            digit_in;
  logic                          digit_btn;
  logic                          clear_btn;
  logic [DIGIT_W*NUM_DIGITS-1:0] data_out;
  logic                          data_load;
  logic [2:0]                    digit_count;
  logic                          entry_active;
  logic                          entry_timeout;

  modport slave (
    input  digit_in, digit_btn, clear_btn,
    output data_out, data_load, digit_count,
    output entry_active, entry_timeout
  );

  modport master (
    output digit_in, digit_btn, clear_btn,
    input  data_out, data_load, digit_count,
    input  entry_active, entry_timeout
  );

endinterface

// File: rtl/password_entry_rise_edge_detect.sv
// Registered rising-edge one-shot: event_o = btn_i & ~btn_q.
// Ports: clk, rst (sync, high), btn_i level in, event_o pulse out.
module rise_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic event_o
);

  logic btn_q;

  // History resets high so a button held through reset gives no edge.
  always_ff @(posedge clk) begin
    if (rst) btn_q <= 1'b1;
    else     btn_q <= btn_i;
  end

  assign event_o = btn_i & ~btn_q;

endmodule

// File: rtl/password_entry.sv
// Collects NUM_DIGITS keypad digits into one word with a load strobe.
// Ports: clk, rst (sync, high), bus (password_entry_if.slave).
// Optional idle timeout: define PASSWORD_ENTRY_TIMEOUT_EN.
module password_entry
  import password_entry_pkg::*;
#(
  parameter int DIGIT_W        = DEF_DIGIT_W,
  parameter int NUM_DIGITS     = DEF_NUM_DIGITS,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic              clk,
  input  logic              rst,
  password_entry_if.slave   bus
);

  localparam int PW_W = DIGIT_W * NUM_DIGITS;
  localparam logic [2:0] LAST = 3'(NUM_DIGITS - 1);

  logic            dig_ev;
  logic            clr_ev;
  logic [1:0]      state_q, state_d;
  logic [PW_W-1:0] shift_q, shift_d;
  logic [PW_W-1:0] data_q, data_d;
  logic [PW_W-1:0] shifted;
  logic [2:0]      count_q, count_d;
  logic            load_q, load_d;
  logic            tmo_q, tmo_d;
  logic            expire;

  rise_edge_detect u_dig (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (bus.digit_btn),
    .event_o (dig_ev)
  );

  rise_edge_detect u_clr (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (bus.clear_btn),
    .event_o (clr_ev)
  );

  assign shifted = (shift_q << DIGIT_W)
                 | PW_W'(bus.digit_in);

`ifdef PASSWORD_ENTRY_TIMEOUT_EN
  logic [31:0] idle_q, idle_d;

  assign expire = (state_q == COLLECT)
               && (idle_q == 32'(TIMEOUT_CYCLES - 1));

  // Counts only while staying in COLLECT without a new digit.
  always_comb begin
    idle_d = '0;
    if (state_q == COLLECT && state_d == COLLECT && !dig_ev)
      idle_d = idle_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) idle_q <= '0;
    else     idle_q <= idle_d;
  end
`else
  logic [31:0] unused_tmo;
  assign unused_tmo = 32'(TIMEOUT_CYCLES);
  assign expire     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    data_d  = data_q;
    count_d = count_q;
    load_d  = 1'b0;
    tmo_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clr_ev) begin
          shift_d = '0;
          count_d = '0;
        end else if (dig_ev) begin
          if (NUM_DIGITS == 1) begin
            data_d  = shifted;
            shift_d = '0;
            load_d  = 1'b1;
            state_d = EMIT;
          end else begin
            shift_d = shifted;
            count_d = 3'd1;
            state_d = COLLECT;
          end
        end
      end
      COLLECT: begin
        // Clear beats a same-cycle digit; a digit beats expiry.
        if (clr_ev) begin
          shift_d = '0;
          count_d = '0;
          state_d = IDLE;
        end else if (dig_ev) begin
          if (count_q == LAST) begin
            data_d  = shifted;
            shift_d = '0;
            count_d = '0;
            load_d  = 1'b1;
            state_d = EMIT;
          end else begin
            shift_d = shifted;
            count_d = count_q + 3'd1;
          end
        end else if (expire) begin
          shift_d = '0;
          count_d = '0;
          tmo_d   = 1'b1;
          state_d = IDLE;
        end
      end
      EMIT: begin
        state_d = IDLE;
      end
      default: begin
        shift_d = '0;
        count_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      data_q  <= '0;
      count_q <= '0;
      load_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      count_q <= count_d;
      load_q  <= load_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.data_out      = data_q;
  assign bus.data_load     = load_q;
  assign bus.digit_count   = count_q;
  assign bus.entry_active  = (state_q == COLLECT);
  assign bus.entry_timeout = tmo_q;

endmodule

// File: tb/tb_password_entry.sv
// Directed self-checking bench for password_entry.
// Uses TIMEOUT_CYCLES=10; timeout test follows PASSWORD_ENTRY_TIMEOUT_EN.
module tb_password_entry;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   load_cnt;

  password_entry_if pe_if ();

  password_entry #(
    .DIGIT_W        (4),
    .NUM_DIGITS     (4),
    .TIMEOUT_CYCLES (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (pe_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (pe_if.data_load) load_cnt++;
  endtask

  task automatic press(input logic [3:0] d);
    pe_if.digit_in  = d;
    pe_if.digit_btn = 1'b1;
    repeat (3) tick();
    pe_if.digit_btn = 1'b0;
    tick();
  endtask

  task automatic clear_press();
    pe_if.clear_btn = 1'b1;
    repeat (2) tick();
    pe_if.clear_btn = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if (pe_if.data_out !== 16'h0) begin
      errors++;
      $display("FAIL reset_data_out got %h want 0000", pe_if.data_out);
    end
    checks++;
    if (pe_if.data_load !== 1'b0 || pe_if.entry_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes got load=%b tmo=%b want 0 0",
               pe_if.data_load, pe_if.entry_timeout);
    end
    checks++;
    if (pe_if.digit_count !== 3'd0 || pe_if.entry_active !== 1'b0) begin
      errors++;
      $display("FAIL reset_status got cnt=%0d act=%b want 0 0",
               pe_if.digit_count, pe_if.entry_active);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [3:0] seq [3];
    seq = '{4'h1, 4'h2, 4'h3};
    load_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      press(seq[i]);
      checks++;
      if (pe_if.digit_count !== 3'(i + 1) || pe_if.entry_active !== 1'b1) begin
        errors++;
        $display("FAIL basic_progress%0d got cnt=%0d act=%b want %0d 1",
                 i, pe_if.digit_count, pe_if.entry_active, i + 1);
      end
    end
    pe_if.digit_in  = 4'h4;
    pe_if.digit_btn = 1'b1;
    tick();
    checks++;
    if (pe_if.data_load !== 1'b1 || pe_if.data_out !== 16'h1234) begin
      errors++;
      $display("FAIL basic_load got load=%b data=%h want 1 1234",
               pe_if.data_load, pe_if.data_out);
    end
    tick();
    checks++;
    if (pe_if.data_load !== 1'b0 || pe_if.entry_active !== 1'b0 ||
        pe_if.digit_count !== 3'd0) begin
      errors++;
      $display("FAIL basic_after got load=%b act=%b cnt=%0d want 0 0 0",
               pe_if.data_load, pe_if.entry_active, pe_if.digit_count);
    end
    pe_if.digit_btn = 1'b0;
    repeat (3) tick();
    checks++;
    if (load_cnt !== 1 || pe_if.data_out !== 16'h1234) begin
      errors++;
      $display("FAIL basic_single got loads=%0d data=%h want 1 1234",
               load_cnt, pe_if.data_out);
    end
  endtask

  task automatic test_clear();
    load_cnt = 0;
    press(4'h5);
    press(4'h6);
    clear_press();
    checks++;
    if (load_cnt !== 0 || pe_if.digit_count !== 3'd0 ||
        pe_if.entry_active !== 1'b0) begin
      errors++;
      $display("FAIL clear_discard got loads=%0d cnt=%0d act=%b want 0 0 0",
               load_cnt, pe_if.digit_count, pe_if.entry_active);
    end
    press(4'hA);
    press(4'hB);
    press(4'hC);
    checks++;
    if (pe_if.data_out !== 16'h1234 || load_cnt !== 0) begin
      errors++;
      $display("FAIL clear_retain got data=%h loads=%0d want 1234 0",
               pe_if.data_out, load_cnt);
    end
    press(4'hD);
    checks++;
    if (pe_if.data_out !== 16'hABCD || load_cnt !== 1) begin
      errors++;
      $display("FAIL clear_reload got data=%h loads=%0d want abcd 1",
               pe_if.data_out, load_cnt);
    end
  endtask

  task automatic test_hold_and_collide();
    pe_if.digit_in  = 4'h7;
    pe_if.digit_btn = 1'b1;
    repeat (20) tick();
    pe_if.digit_btn = 1'b0;
    tick();
    checks++;
    if (pe_if.digit_count !== 3'd1) begin
      errors++;
      $display("FAIL hold_one got cnt=%0d want 1", pe_if.digit_count);
    end
    pe_if.digit_in  = 4'h9;
    pe_if.digit_btn = 1'b1;
    pe_if.clear_btn = 1'b1;
    tick();
    checks++;
    if (pe_if.digit_count !== 3'd0 || pe_if.entry_active !== 1'b0) begin
      errors++;
      $display("FAIL collide got cnt=%0d act=%b want 0 0",
               pe_if.digit_count, pe_if.entry_active);
    end
    pe_if.digit_btn = 1'b0;
    pe_if.clear_btn = 1'b0;
    tick();
    load_cnt = 0;
    press(4'h9);
    press(4'h8);
    press(4'h7);
    checks++;
    if (load_cnt !== 0 || pe_if.digit_count !== 3'd3) begin
      errors++;
      $display("FAIL collide_resume got loads=%0d cnt=%0d want 0 3",
               load_cnt, pe_if.digit_count);
    end
    press(4'h6);
    checks++;
    if (load_cnt !== 1 || pe_if.data_out !== 16'h9876) begin
      errors++;
      $display("FAIL collide_word got loads=%0d data=%h want 1 9876",
               load_cnt, pe_if.data_out);
    end
  endtask

  task automatic test_reset_mid();
    press(4'h1);
    press(4'h2);
    pe_if.digit_in  = 4'h3;
    pe_if.digit_btn = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (pe_if.data_out !== 16'h0 || pe_if.digit_count !== 3'd0 ||
        pe_if.entry_active !== 1'b0 || pe_if.data_load !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got data=%h cnt=%0d act=%b load=%b want 0",
               pe_if.data_out, pe_if.digit_count,
               pe_if.entry_active, pe_if.data_load);
    end
    load_cnt = 0;
    repeat (5) tick();
    checks++;
    if (pe_if.digit_count !== 3'd0 || load_cnt !== 0) begin
      errors++;
      $display("FAIL rst_held got cnt=%0d loads=%0d want 0 0",
               pe_if.digit_count, load_cnt);
    end
    pe_if.digit_btn = 1'b0;
    tick();
    press(4'h8);
    checks++;
    if (pe_if.digit_count !== 3'd1) begin
      errors++;
      $display("FAIL rst_repress got cnt=%0d want 1", pe_if.digit_count);
    end
    clear_press();
  endtask

  task automatic test_emit_ignore();
    press(4'h4);
    press(4'h3);
    press(4'h2);
    load_cnt = 0;
    pe_if.digit_in  = 4'h1;
    pe_if.digit_btn = 1'b1;
    tick();
    pe_if.digit_in  = 4'hF;
    pe_if.clear_btn = 1'b1;
    tick();
    pe_if.clear_btn = 1'b0;
    repeat (2) tick();
    pe_if.digit_btn = 1'b0;
    tick();
    checks++;
    if (pe_if.digit_count !== 3'd0 || pe_if.entry_active !== 1'b0 ||
        pe_if.data_out !== 16'h4321 || load_cnt !== 1) begin
      errors++;
      $display("FAIL emit_ignore got cnt=%0d act=%b data=%h loads=%0d want 0 0 4321 1",
               pe_if.digit_count, pe_if.entry_active,
               pe_if.data_out, load_cnt);
    end
  endtask

  task automatic test_idle();
    int n;
    bit seen;
    load_cnt = 0;
    press(4'h2);
    pe_if.digit_in  = 4'h5;
    pe_if.digit_btn = 1'b1;
    tick();
    pe_if.digit_btn = 1'b0;
`ifdef PASSWORD_ENTRY_TIMEOUT_EN
    n = 0;
    seen = 1'b0;
    while (!seen && n < 30) begin
      tick();
      n++;
      if (pe_if.entry_timeout === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || n !== 10) begin
      errors++;
      $display("FAIL timeout_delay got seen=%b cycles=%0d want 1 10", seen, n);
    end
    tick();
    checks++;
    if (pe_if.entry_timeout !== 1'b0 || pe_if.digit_count !== 3'd0 ||
        pe_if.entry_active !== 1'b0 || load_cnt !== 0) begin
      errors++;
      $display("FAIL timeout_after got tmo=%b cnt=%0d act=%b loads=%0d want 0 0 0 0",
               pe_if.entry_timeout, pe_if.digit_count,
               pe_if.entry_active, load_cnt);
    end
`else
    n = 0;
    seen = 1'b0;
    repeat (1000) begin
      tick();
      n++;
      if (pe_if.entry_timeout !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen || pe_if.digit_count !== 3'd2 ||
        pe_if.entry_active !== 1'b1 || load_cnt !== 0) begin
      errors++;
      $display("FAIL idle_retain got tmo=%b cnt=%0d act=%b loads=%0d want 0 2 1 0",
               seen, pe_if.digit_count, pe_if.entry_active, load_cnt);
    end
    clear_press();
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    load_cnt = 0;
    rst = 1'b1;
    pe_if.digit_in  = 4'h0;
    pe_if.digit_btn = 1'b0;
    pe_if.clear_btn = 1'b0;
    test_reset();
    test_basic();
    test_clear();
    test_hold_and_collide();
    test_reset_mid();
    test_emit_ignore();
    test_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
